// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue instruction fetch stage with a one-cycle ROM tracker and a pair FIFO
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rom_addr                   : ROM word index of the pair being issued this cycle
//   rom_instr1, rom_instr2     : ROM words for the index sampled on the previous edge
//   redirect_valid/redirect_pc : flush everything and refetch from the target
//   if_valid/if_ready          : decode handshake on the FIFO head
//   if_pc, if_instr1/2         : head pair; if_valid2 flags a usable second slot
module fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr1,
    input  logic [31:0]       rom_instr2,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr1,
    output logic [31:0]       if_instr2,
    output logic              if_valid2
);
    localparam int          PW   = $clog2(DEPTH);
    localparam int          CW   = PW + 1;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [31:0]       fetch_pc, req_pc, issue_pc, next_pc;
    logic              req_valid, req_last, issue, last, push, pop;
    logic [CW-1:0]     count, occ;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [31:0]       pc_q [DEPTH];
    logic [31:0]       i1_q [DEPTH];
    logic [31:0]       i2_q [DEPTH];
    logic [DEPTH-1:0]  v2_q;
    // Occupancy counts the in-flight ROM read so its push can never overflow.
    // A redirect bypasses the occupancy gate because the flush empties the queue.
    always_comb begin
        occ      = count + CW'(req_valid);
        issue_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc;
        issue    = redirect_valid || (occ < FULL);
        rom_addr = issue_pc[ADDR_W+1:2];
        last     = &rom_addr;
        next_pc  = issue_pc + (last ? 32'd4 : 32'd8);
        push     = req_valid && !redirect_valid;
        pop      = if_valid && if_ready && !redirect_valid;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
            req_last  <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            req_valid <= issue;
            req_pc    <= issue_pc;
            req_last  <= last;
            if (issue) fetch_pc <= next_pc;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr] <= req_pc;
            i1_q[wr_ptr] <= rom_instr1;
            i2_q[wr_ptr] <= rom_instr2;
            v2_q[wr_ptr] <= !req_last;
        end
    end
    assign if_valid  = count != '0;
    assign if_pc     = if_valid ? pc_q[rd_ptr] : 32'h0;
    assign if_instr1 = if_valid ? i1_q[rd_ptr] : NOP;
    assign if_instr2 = if_valid ? i2_q[rd_ptr] : NOP;
    assign if_valid2 = if_valid && v2_q[rd_ptr];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit against a queue-based reference
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rom_addr;
    logic [31:0] rom_instr1, rom_instr2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, if_valid2;
    logic [31:0] if_pc, if_instr1, if_instr2;
    logic [31:0] rom [0:1023];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    bit          infl_v;
    logic [31:0] infl_pc, mpc;
    logic        s_v, s_v2;
    logic [31:0] s_pc, s_i1, s_i2, s_ra;

    fetch_unit #(.ADDR_W(10), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr),
        .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr1(if_instr1), .if_instr2(if_instr2), .if_valid2(if_valid2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_instr1 <= rom[rom_addr];
        rom_instr2 <= rom[rom_addr + 10'd1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        infl_v = 0;
        infl_pc = 0;
        mpc = 32'h0;
    endtask

    // One clock cycle: drive inputs, compare DUT against the model on the falling edge,
    // then advance the model across the rising edge.
    task automatic cyc(input bit r, input logic [31:0] t, input bit rdy);
        logic [31:0] ip, hp;
        bit iss;
        redirect_valid = r;
        redirect_pc = t;
        if_ready = rdy;
        ip = r ? {t[31:2], 2'b00} : mpc;
        iss = r || (q.size() + int'(infl_v) < DEPTH);
        @(negedge clk);
        s_v = if_valid; s_v2 = if_valid2; s_pc = if_pc;
        s_i1 = if_instr1; s_i2 = if_instr2; s_ra = 32'(rom_addr);
        check("rom_addr", 32'(rom_addr), 32'(ip[11:2]));
        if (q.size() > 0) begin
            hp = q[0];
            check("if_valid", 32'(if_valid), 32'd1);
            check("if_pc", if_pc, hp);
            check("if_instr1", if_instr1, rom[hp[11:2]]);
            check("if_instr2", if_instr2, rom[hp[11:2] + 10'd1]);
            check("if_valid2", 32'(if_valid2), 32'(hp[11:2] != 10'h3ff));
        end else begin
            check("idle_valid", 32'(if_valid), 32'd0);
            check("idle_pc", if_pc, 32'h0);
            check("idle_instr1", if_instr1, NOP);
            check("idle_instr2", if_instr2, NOP);
            check("idle_valid2", 32'(if_valid2), 32'd0);
        end
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (infl_v) q.push_back(infl_pc);
        end
        infl_v = iss;
        infl_pc = ip;
        if (iss) mpc = ip + ((ip[11:2] == 10'h3ff) ? 32'd4 : 32'd8);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 0;
        rst_n = 0;
        #1;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        logic [31:0] t;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0] = 32'h00100293; rom[1] = 32'h00200313;
        rom[2] = 32'h0062a023; rom[3] = 32'h00a00c23;
        rom[10] = 32'h00032903; rom[11] = 32'h00d50733;
        rst_n = 0; redirect_valid = 0; redirect_pc = 0; if_ready = 1;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst0_addr", 32'(rom_addr), 32'd0);
        check("rst0_valid", 32'(if_valid), 32'd0);
        check("rst0_instr1", if_instr1, NOP);
        check("rst0_valid2", 32'(if_valid2), 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        // start-up latency
        cyc(0, 0, 1); check("su_c0", 32'(s_v), 32'd0);
        cyc(0, 0, 1); check("su_c1", 32'(s_v), 32'd0);
        cyc(0, 0, 1);
        check("su_c2_pc", s_pc, 32'h0);
        check("su_c2_i1", s_i1, 32'h00100293);
        check("su_c2_i2", s_i2, 32'h00200313);
        check("su_c2_v2", 32'(s_v2), 32'd1);
        cyc(0, 0, 1);
        check("su_c3_pc", s_pc, 32'h8);
        check("su_c3_i1", s_i1, 32'h0062a023);
        check("su_c3_i2", s_i2, 32'h00a00c23);
        // backpressure from a fresh start
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        check("bp_pc", s_pc, 32'h0);
        check("bp_ra", s_ra, 32'd8);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            check("bp_seq_v", 32'(s_v), 32'd1);
            check("bp_seq_pc", s_pc, 32'(i * 8));
        end
        // redirect with a full queue
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);
        cyc(1, 32'h28, 0);
        cyc(0, 0, 1); check("rf_gap", 32'(s_v), 32'd0);
        cyc(0, 0, 1);
        check("rf_pc", s_pc, 32'h28);
        check("rf_i1", s_i1, 32'h00032903);
        check("rf_i2", s_i2, 32'h00d50733);
        // redirect coinciding with a pop
        cyc(0, 0, 1);
        t = 32'h100 + 32'($urandom_range(0, 15) << 3);
        cyc(1, t, 1); check("rp_popv", 32'(s_v), 32'd1);
        cyc(0, 0, 1); check("rp_gap", 32'(s_v), 32'd0);
        cyc(0, 0, 1); check("rp_pc", s_pc, t);
        // last ROM word
        cyc(1, 32'hFFD, 1);
        cyc(0, 0, 1); check("wr_ra", s_ra, 32'd0);
        cyc(0, 0, 1);
        check("wr_pc0", s_pc, 32'hFFC);
        check("wr_v2_0", 32'(s_v2), 32'd0);
        cyc(0, 0, 1);
        check("wr_pc1", s_pc, 32'h1000);
        check("wr_v2_1", 32'(s_v2), 32'd1);
        // reset mid-stream with a partly filled queue
        cyc(0, 0, 0); cyc(0, 0, 0);
        check("mr_pre", 32'(s_v), 32'd1);
        do_reset();
        cyc(0, 0, 1); check("mr_c0", 32'(s_v), 32'd0);
        cyc(0, 0, 1); check("mr_c1", 32'(s_v), 32'd0);
        cyc(0, 0, 1);
        check("mr_c2_v", 32'(s_v), 32'd1);
        check("mr_c2_pc", s_pc, 32'h0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t[11:3] = 9'h1ff;
            cyc($urandom_range(0, 15) == 0, t, $urandom_range(0, 2) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
